// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI slave front end and its RAM stage.
package spi_pkg;
  localparam int FRAME_W = 10;
  localparam int DATA_W  = 8;
  localparam int CNT_W   = 4;

  // bit counter values: last frame bit being sampled, and frame complete
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_W - 1);
  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(FRAME_W);

  typedef enum logic [2:0] {
    IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA
  } state_e;

  typedef enum logic [1:0] {
    CMD_WR_ADDR = 2'b00,
    CMD_WR_DATA = 2'b01,
    CMD_RD_ADDR = 2'b10,
    CMD_RD_DATA = 2'b11
  } cmd_e;

  typedef enum logic [1:0] {
    TX_WAIT, TX_SHIFT, TX_HOLD
  } tx_st_e;
endpackage

// File: rtl/spi_tx_serializer.sv
// Parallel-in, serial-out MISO shifter: MSB on the line the cycle after load.
module spi_tx_serializer
  import spi_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              load,
  input  logic [DATA_W-1:0] data,
  output logic              sout,
  output logic              done
);
  logic [DATA_W-1:0] sh_q, sh_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              sout_q, sout_d;

  // cnt_q counts bits still owed including the one on the line now
  always_comb begin
    sh_d   = sh_q;
    cnt_d  = cnt_q;
    sout_d = 1'b0;
    if (clr) begin
      sh_d  = '0;
      cnt_d = '0;
    end else if (load) begin
      sh_d   = {data[DATA_W-2:0], 1'b0};
      cnt_d  = CNT_W'(DATA_W);
      sout_d = data[DATA_W-1];
    end else if (cnt_q > 4'd1) begin
      sout_d = sh_q[DATA_W-1];
      sh_d   = sh_q << 1;
      cnt_d  = cnt_q - 4'd1;
    end else begin
      sh_d  = '0;
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q   <= '0;
      cnt_q  <= '0;
      sout_q <= 1'b0;
    end else begin
      sh_q   <= sh_d;
      cnt_q  <= cnt_d;
      sout_q <= sout_d;
    end
  end

  assign sout = sout_q;
  assign done = (cnt_q == 4'd1);
endmodule

// File: rtl/spi_slave.sv
// SPI slave: receives 10-bit command frames, strobes them to the RAM stage,
// and shifts read data back on MISO for read-data frames.
module spi_slave
  import spi_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               SS_n,
  input  logic               MOSI,
  output logic               MISO,
  output logic [FRAME_W-1:0] rx_data,
  output logic               rx_valid,
  input  logic [DATA_W-1:0]  tx_data,
  input  logic               tx_valid
);
  state_e               state_q, state_d;
  tx_st_e               tx_st_q, tx_st_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [FRAME_W-2:0]   shreg_q, shreg_d;
  logic [FRAME_W-1:0]   rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 rd_addr_flag_q, rd_addr_flag_d;
  logic                 ser_load, ser_done, ser_miso;

  always_comb begin
    state_d        = state_q;
    tx_st_d        = tx_st_q;
    cnt_d          = cnt_q;
    shreg_d        = shreg_q;
    rx_data_d      = rx_data_q;
    rx_valid_d     = 1'b0;
    rd_addr_flag_d = rd_addr_flag_q;
    ser_load       = 1'b0;
    if (state_q == IDLE) begin
      cnt_d   = '0;
      tx_st_d = TX_WAIT;
      if (!SS_n) state_d = CHK_CMD;
    end else if (SS_n) begin
      state_d = IDLE;
    end else begin
      // once the frame is complete MOSI is ignored until SS_n rises
      if (cnt_q < CNT_DONE) begin
        shreg_d = {shreg_q[FRAME_W-3:0], MOSI};
        cnt_d   = cnt_q + 4'd1;
      end
      case (state_q)
        CHK_CMD: state_d = !MOSI ? WRITE : (rd_addr_flag_q ? READ_DATA : READ_ADD);
        default: begin
          if (cnt_q == CNT_LAST) begin
            rx_data_d  = {shreg_q, MOSI};
            rx_valid_d = 1'b1;
            if (state_q == READ_ADD)       rd_addr_flag_d = 1'b1;
            else if (state_q == READ_DATA) rd_addr_flag_d = 1'b0;
          end
        end
      endcase
      // one capture per frame; a tx_valid held high must not reload
      if (state_q == READ_DATA && cnt_q == CNT_DONE) begin
        case (tx_st_q)
          TX_WAIT: if (tx_valid) begin
            ser_load = 1'b1;
            tx_st_d  = TX_SHIFT;
          end
          TX_SHIFT: if (ser_done) tx_st_d = TX_HOLD;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      tx_st_q        <= TX_WAIT;
      cnt_q          <= '0;
      shreg_q        <= '0;
      rx_data_q      <= '0;
      rx_valid_q     <= 1'b0;
      rd_addr_flag_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      tx_st_q        <= tx_st_d;
      cnt_q          <= cnt_d;
      shreg_q        <= shreg_d;
      rx_data_q      <= rx_data_d;
      rx_valid_q     <= rx_valid_d;
      rd_addr_flag_q <= rd_addr_flag_d;
    end
  end

  spi_tx_serializer u_tx (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (SS_n),
    .load  (ser_load),
    .data  (tx_data),
    .sout  (ser_miso),
    .done  (ser_done)
  );

  assign MISO     = ser_miso;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
endmodule

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Ports SHALL be, in order:
- clk  in  1  sole clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- SS_n  in  1  slave select, active low; frames only while low
- MOSI  in  1  serial data in, MSB first, sampled on clk rising edge
- MISO  out  1  serial data out, MSB first
- rx_data  out  10  parallel frame to the RAM stage (bits 9:8 = command, 7:0 = payload)
- rx_valid  out  1  one-cycle strobe; rx_data valid
- tx_data  in  8  read data returned by the RAM stage
- tx_valid  in  1  tx_data valid

Function
REQ-003 The FSM SHALL have the states IDLE, CHK_CMD, WRITE, READ_ADD and READ_DATA.
REQ-004 IDLE SHALL move to CHK_CMD on the cycle after SS_n is sampled low; otherwise it SHALL hold.
REQ-005 Frame format: 10 bits, MSB first, one bit per clk. Bit 9 SHALL be sampled in CHK_CMD. Bits 8..0 SHALL be sampled in the next 9 cycles.
REQ-006 CHK_CMD next state:
- MOSI=0 -> WRITE
- MOSI=1 with rd_addr_flag=0 -> READ_ADD
- MOSI=1 with rd_addr_flag=1 -> READ_DATA
REQ-007 The state SHALL be selected only by bit 9 and rd_addr_flag; all 10 received bits SHALL be forwarded on rx_data unmodified.
REQ-008 Once bit 0 has been sampled with SS_n low, rx_data SHALL hold the frame and rx_valid SHALL be 1 for exactly the next cycle, i.e. 11 cycles after SS_n is first sampled low.
REQ-009 rx_valid SHALL be issued even if SS_n rises in the cycle after bit 0.
REQ-010 rx_data SHALL hold its value until the next completed frame.
REQ-011 rd_addr_flag SHALL be set when a READ_ADD frame completes and cleared when a READ_DATA frame completes.
REQ-012 After its rx_valid pulse, READ_DATA SHALL wait for tx_valid=1 and capture tx_data once per frame; tx_valid that stays high SHALL NOT cause a recapture.
REQ-013 Starting the cycle after capture, MISO SHALL drive tx_data[7] down to tx_data[0], one bit per cycle for 8 cycles, then return to 0.
REQ-014 MISO SHALL be 0 in every other state and cycle.
REQ-015 SS_n sampled high in any non-IDLE state SHALL force IDLE on the next cycle:
- the partial frame is discarded with no rx_valid
- any serialisation in progress is aborted and MISO goes to 0
- rd_addr_flag is retained
REQ-016 After the frame/serialisation completes, the FSM SHALL hold in its state, ignoring MOSI, until SS_n goes high.
REQ-017 The bit counter SHALL be 4 bits and SHALL reset to 0 on every entry to CHK_CMD.

Reset
REQ-018 rst_n low SHALL immediately (asynchronously) force:
- state = IDLE
- MISO = 0, rx_data = 0, rx_valid = 0
- rd_addr_flag = 0
- bit counter = 0
- serialiser register = 0
REQ-019 Reset asserted mid-frame or mid-serialisation SHALL abort it with no rx_valid.
REQ-020 After rst_n releases, the first frame with bit 9=1 SHALL be treated as READ_ADD.

Structure
REQ-021 A shared package spi_pkg SHALL hold:
- state enum
- FRAME_W=10, DATA_W=8
- command codes: 00 wr-addr, 01 wr-data, 10 rd-addr, 11 rd-data
REQ-022 One sub-module spi_tx_serializer (load, 8-bit parallel-in, serial-out, done) SHALL implement the MISO path.
REQ-023 The existing spi_wrapper SHALL instantiate spi_slave alongside the RAM stage.

Verification
REQ-024 Write address: SS_n low, MOSI 0010100101 -> rx_data=0x0A5, rx_valid high 1 cycle at cycle 11, MISO=0 throughout.
REQ-025 Write data: MOSI 0100111100 -> rx_data=0x13C, single rx_valid, rd_addr_flag stays 0.
REQ-026 Read address: MOSI 1011110000 -> rx_data=0x2F0, rd_addr_flag=1; the next frame starting with 1 enters READ_DATA.
REQ-027 Read data: MOSI 1100000000, tx_data=0xC3 with tx_valid held high 3 cycles -> rx_data=0x300; MISO 1,1,0,0,0,0,1,1 on 8 consecutive cycles from the cycle after first tx_valid sample, then 0; rd_addr_flag=0.
REQ-028 Abort: SS_n high after 5 bits -> no rx_valid, IDLE next cycle; rst_n low during MISO bit 3 -> MISO=0, rx_valid=0 immediately.
